addr_tmr_pipe: RTL and testbench
================================

Name: addr_tmr_pipe

Overview:
- Parametrised, pipelined, fault-resilient unsigned adder; successor to the fixed 8-bit combinational fault-resilient adders in the library.
- Splits the WIDTH-bit carry chain into SEG-bit segments, one segment per pipeline stage.
- Each segment is computed by three redundant lanes and majority-voted, so any single-lane fault is masked and reported.
- Valid/ready streaming interface; includes a saturating fault counter and a deterministic fault-injection port for resilience characterisation.

Parameters:
- WIDTH, 8, operand width in bits (>=2).
- SEG, 4, segment width per pipeline stage (1..WIDTH). NSTG = ceil(WIDTH/SEG); the last segment may be narrower.
- CNT_W, 8, fault counter width (>=1).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  operand pair valid.
- in_ready  out  1  block can accept operands.
- a  in  WIDTH  unsigned operand A.
- b  in  WIDTH  unsigned operand B.
- inj_en  in  1  inject a single-bit fault into the transaction accepted this cycle.
- inj_lane  in  2  target lane 0..2; value 3 = no injection.
- inj_bit  in  $clog2(WIDTH+1)  sum bit to flip in the target lane; value WIDTH = that lane's carry-out of the final segment.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts result.
- sum  out  WIDTH+1  voted result a+b, carry in MSB.
- fault_flag  out  1  at least one lane disagreed with the vote for this result (qualified by out_valid).
- clr_cnt  in  1  synchronous clear of fault_cnt.
- fault_cnt  out  CNT_W  saturating count of delivered results with fault_flag=1.

Behaviour:
- Clocking and reset: one clock domain. Reset is synchronous and active-high. Ports are named clk and rst.
- Reset values: all stage valid bits 0, out_valid 0, sum 0, fault_flag 0, fault_cnt 0. in_ready reads 1 from the first cycle after rst deasserts.
- Reset mid-operation discards all in-flight transactions; no partial result is emitted.
- Advance enable: adv = !out_valid || out_ready. All stages shift together when adv=1 and hold otherwise.
- Backpressure: there is no bubble collapse. in_ready = adv. Accept occurs when in_valid && in_ready.
- Latency: a result accepted at edge t appears with out_valid=1 after edge t+NSTG-1 if adv stays 1 (NSTG cycles, fully pipelined, throughput 1/cycle). Example: WIDTH=8, SEG=4 gives 2 cycles.
- Stage k computation:
  - Each lane L computes {c_L, s_L} = a_seg + b_seg + cin_k, with cin_0 = 0.
  - The injected flip is applied to s_L or c_L when the stored injection tag matches (lane, bit within this segment).
  - Voted sum segment = bitwise maj3(s_0, s_1, s_2). Voted carry = maj3(c_0, c_1, c_2); it becomes cin_{k+1} for all lanes.
  - Stage fault bit = any bit where a lane differs from the vote. It is ORed into the transaction's fault tag carried down the pipe.
- Injection: the tag (inj_lane, inj_bit) is captured with the operands only when inj_en && accept; otherwise the tag is no-injection. An inj_lane=3 tag injects nothing. Only one lane is ever corrupted, so sum is always the correct a+b.
- Counter:
  - Increments on each output transfer (out_valid && out_ready) with fault_flag=1, saturating at 2^CNT_W-1.
  - clr_cnt has priority over a simultaneous increment (result 0).
  - rst overrides all.
- Output registers hold stable while out_valid && !out_ready.

Decomposition:
- Package addr_ft_pkg:
  - constant N_LANES=3;
  - function maj3 (bitwise majority);
  - function nstg(WIDTH, SEG);
  - localparam INJ_NONE=2'd3.
- Sub-module addr_tmr_seg: one stage's three lane adders, injection mux, voters and fault-bit generation. Parameterised by segment width and bit offset; instantiated NSTG times in a generate loop. The top holds the pipeline registers, handshake and counter.

Test Plan:
- WIDTH=8, SEG=4: after rst, a=0xFF, b=0x01, out_ready=1 -> 2 cycles later out_valid=1, sum=0x100, fault_flag=0, fault_cnt=0.
- a=0x0F, b=0x01, inj_en=1, inj_lane=1, inj_bit=3 -> sum=0x010, fault_flag=1. fault_cnt=1 after transfer.
- inj_lane=2, inj_bit=8 on a=0x80, b=0x80 -> sum=0x100 (carry fault masked), fault_flag=1. inj_lane=3 with inj_en=1 -> fault_flag=0.
- Back-to-back stream with out_ready=0 for 5 cycles -> in_ready=0 once 2 entries are held. Outputs stay stable; resuming delivers all results in order with none lost.
- CNT_W=2: 5 injected transactions -> fault_cnt saturates at 3. clr_cnt in the same cycle as a faulty transfer -> fault_cnt=0.
- rst asserted with 2 transactions in flight -> next cycle out_valid=0. No stale result ever appears; fault_cnt=0.

Source files
------------

// File: rtl/addr_ft_pkg.sv
// Shared constants and helpers for the triple-lane, segment-pipelined adder.
// Provides the lane count, no-injection tag, stage-count calculation and majority voter.
package addr_ft_pkg;

    localparam int N_LANES = 3;
    localparam logic [1:0] INJ_NONE = 2'd3;

    function automatic int nstg(input int width, input int seg);
        return (width + seg - 1) / seg;
    endfunction

    // Bitwise majority of three bits; callers apply it per bit.
    function automatic logic maj3(input logic x, input logic y, input logic z);
        return (x & y) | (x & z) | (y & z);
    endfunction

endpackage

// File: rtl/addr_tmr_seg.sv
// One pipeline stage: three redundant segment adders with fault injection,
// a bitwise voter, and the disagreement (fault) indicator.
module addr_tmr_seg
    import addr_ft_pkg::*;
#(
    parameter int SW    = 4,
    parameter int OFF   = 0,
    parameter int WIDTH = 8,
    parameter int IW    = 4,
    parameter bit LAST  = 1'b0
) (
    input  logic [SW-1:0] a_seg,
    input  logic [SW-1:0] b_seg,
    input  logic          cin,
    input  logic [1:0]    inj_lane,
    input  logic [IW-1:0] inj_bit,
    output logic [SW-1:0] sum_seg,
    output logic          cout,
    output logic          fault
);

    logic [SW:0]   raw_s [N_LANES];
    logic [SW-1:0] lane_s [N_LANES];
    logic          lane_c [N_LANES];

    // Lane adders with the injected flip, then voting and fault detection.
    always_comb begin
        for (int l = 0; l < N_LANES; l++) begin
            raw_s[l]  = (SW+1)'(a_seg) + (SW+1)'(b_seg) + (SW+1)'(cin);
            lane_s[l] = raw_s[l][SW-1:0];
            lane_c[l] = raw_s[l][SW];
            if (inj_lane == 2'(l)) begin
                for (int i = 0; i < SW; i++) begin
                    if (inj_bit == IW'(OFF + i)) begin
                        lane_s[l][i] = ~lane_s[l][i];
                    end else begin
                        lane_s[l][i] = lane_s[l][i];
                    end
                end
                // Carry-out of the final segment is addressed as bit WIDTH.
                if (LAST && (inj_bit == IW'(WIDTH))) begin
                    lane_c[l] = ~lane_c[l];
                end else begin
                    lane_c[l] = lane_c[l];
                end
            end else begin
                lane_c[l] = lane_c[l];
            end
        end

        for (int i = 0; i < SW; i++) begin
            sum_seg[i] = maj3(lane_s[0][i], lane_s[1][i], lane_s[2][i]);
        end
        cout = maj3(lane_c[0], lane_c[1], lane_c[2]);

        fault = 1'b0;
        for (int l = 0; l < N_LANES; l++) begin
            fault = fault | (|(lane_s[l] ^ sum_seg)) | (lane_c[l] ^ cout);
        end
    end

endmodule

// File: rtl/addr_tmr_pipe.sv
// Pipelined fault-resilient adder: one voted segment per stage, all stages
// advance together, plus a saturating count of faulty delivered results.
module addr_tmr_pipe
    import addr_ft_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int SEG   = 4,
    parameter int CNT_W = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [WIDTH-1:0]           a,
    input  logic [WIDTH-1:0]           b,
    input  logic                       inj_en,
    input  logic [1:0]                 inj_lane,
    input  logic [$clog2(WIDTH+1)-1:0] inj_bit,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [WIDTH:0]             sum,
    output logic                       fault_flag,
    input  logic                       clr_cnt,
    output logic [CNT_W-1:0]           fault_cnt
);

    localparam int NSTG = nstg(WIDTH, SEG);
    localparam int IW   = $clog2(WIDTH + 1);
    localparam int NP   = (NSTG > 1) ? (NSTG - 1) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    // Inter-stage registers; the final stage writes the output registers instead.
    logic             v_q   [NP];
    logic [WIDTH-1:0] a_q   [NP];
    logic [WIDTH-1:0] b_q   [NP];
    logic [WIDTH-1:0] s_q   [NP];
    logic             c_q   [NP];
    logic             f_q   [NP];
    logic [1:0]       l_q   [NP];
    logic [IW-1:0]    bit_q [NP];

    logic             out_valid_q;
    logic [WIDTH:0]   sum_q;
    logic             fault_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             adv_s;

    assign adv_s      = !out_valid_q || out_ready;
    assign in_ready   = adv_s;
    assign out_valid  = out_valid_q;
    assign sum        = sum_q;
    assign fault_flag = fault_q;
    assign fault_cnt  = cnt_q;

    for (genvar k = 0; k < NSTG; k++) begin : g_stg
        localparam int LO = k * SEG;
        localparam int HI = ((LO + SEG) > WIDTH) ? (WIDTH - 1) : (LO + SEG - 1);
        localparam int SW = HI - LO + 1;

        logic [SW-1:0]    a_seg_s, b_seg_s, seg_sum_s;
        logic [WIDTH-1:0] st_s_s, nx_s_s;
        logic             st_c_s, st_f_s, st_v_s, seg_c_s, seg_f_s;
        logic [1:0]       st_l_s;
        logic [IW-1:0]    st_b_s;

        if (k == 0) begin : g_src
            assign a_seg_s = a[HI:LO];
            assign b_seg_s = b[HI:LO];
            assign st_s_s  = {WIDTH{1'b0}};
            assign st_c_s  = 1'b0;
            assign st_f_s  = 1'b0;
            assign st_v_s  = in_valid;
            // The tag is only meaningful when inj_en accompanies an accept.
            assign st_l_s  = inj_en ? inj_lane : INJ_NONE;
            assign st_b_s  = inj_bit;
        end else begin : g_src
            assign a_seg_s = a_q[k-1][HI:LO];
            assign b_seg_s = b_q[k-1][HI:LO];
            assign st_s_s  = s_q[k-1];
            assign st_c_s  = c_q[k-1];
            assign st_f_s  = f_q[k-1];
            assign st_v_s  = v_q[k-1];
            assign st_l_s  = l_q[k-1];
            assign st_b_s  = bit_q[k-1];
        end

        addr_tmr_seg #(
            .SW   (SW),
            .OFF  (LO),
            .WIDTH(WIDTH),
            .IW   (IW),
            .LAST (k == NSTG - 1)
        ) u_seg (
            .a_seg   (a_seg_s),
            .b_seg   (b_seg_s),
            .cin     (st_c_s),
            .inj_lane(st_l_s),
            .inj_bit (st_b_s),
            .sum_seg (seg_sum_s),
            .cout    (seg_c_s),
            .fault   (seg_f_s)
        );

        // Merge this stage's voted segment into the partial sum.
        always_comb begin
            nx_s_s        = st_s_s;
            nx_s_s[HI:LO] = seg_sum_s;
        end

        if (k < NSTG - 1) begin : g_pipe
            logic [WIDTH-1:0] fa_s, fb_s;

            if (k == 0) begin : g_fwd
                assign fa_s = a;
                assign fb_s = b;
            end else begin : g_fwd
                assign fa_s = a_q[k-1];
                assign fb_s = b_q[k-1];
            end

            // Stage register: operands travel along for the later segments.
            always_ff @(posedge clk) begin
                if (rst) begin
                    v_q[k]   <= 1'b0;
                    a_q[k]   <= {WIDTH{1'b0}};
                    b_q[k]   <= {WIDTH{1'b0}};
                    s_q[k]   <= {WIDTH{1'b0}};
                    c_q[k]   <= 1'b0;
                    f_q[k]   <= 1'b0;
                    l_q[k]   <= INJ_NONE;
                    bit_q[k] <= {IW{1'b0}};
                end else if (adv_s) begin
                    v_q[k]   <= st_v_s;
                    a_q[k]   <= fa_s;
                    b_q[k]   <= fb_s;
                    s_q[k]   <= nx_s_s;
                    c_q[k]   <= seg_c_s;
                    f_q[k]   <= st_f_s | seg_f_s;
                    l_q[k]   <= st_l_s;
                    bit_q[k] <= st_b_s;
                end
            end
        end else begin : g_out
            // Output register; holds while the consumer stalls.
            always_ff @(posedge clk) begin
                if (rst) begin
                    out_valid_q <= 1'b0;
                    sum_q       <= {(WIDTH+1){1'b0}};
                    fault_q     <= 1'b0;
                end else if (adv_s) begin
                    out_valid_q <= st_v_s;
                    sum_q       <= {seg_c_s, nx_s_s};
                    fault_q     <= st_f_s | seg_f_s;
                end
            end
        end
    end

    // Counter next state: clear wins over increment, increment saturates.
    always_comb begin
        if (clr_cnt) begin
            cnt_d = {CNT_W{1'b0}};
        end else if (out_valid_q && out_ready && fault_q && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Fault counter register.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= {CNT_W{1'b0}};
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: tb/tb_addr_tmr_pipe.sv
// Randomized and directed bench for addr_tmr_pipe against a queue-based
// model that predicts a+b, the fault flag, and the saturating counter.
module tb_addr_tmr_pipe;

    localparam int WIDTH = 8;
    localparam int SEG   = 4;
    localparam int CNT_W = 2;
    localparam int IW    = $clog2(WIDTH + 1);
    localparam int CMAX  = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid, in_ready;
    logic [WIDTH-1:0] a, b;
    logic             inj_en;
    logic [1:0]       inj_lane;
    logic [IW-1:0]    inj_bit;
    logic             out_valid, out_ready;
    logic [WIDTH:0]   sum;
    logic             fault_flag;
    logic             clr_cnt;
    logic [CNT_W-1:0] fault_cnt;

    always #5 clk = ~clk;

    addr_tmr_pipe #(.WIDTH(WIDTH), .SEG(SEG), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .inj_en    (inj_en),
        .inj_lane  (inj_lane),
        .inj_bit   (inj_bit),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .fault_flag(fault_flag),
        .clr_cnt   (clr_cnt),
        .fault_cnt (fault_cnt)
    );

    typedef struct {
        logic [WIDTH:0] s;
        logic           f;
    } exp_t;

    exp_t q[$];
    int   m_cnt;
    int   total = 0;
    int   bad   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h", tag, got, exp);
        end
    endtask

    // Drive one cycle, update the model for what the coming edge does, then check.
    task automatic step(input bit r, input bit iv, input logic [WIDTH-1:0] av,
                        input logic [WIDTH-1:0] bv, input bit ie, input logic [1:0] il,
                        input logic [IW-1:0] ib, input bit ordy, input bit clr);
        exp_t e;
        rst = r; in_valid = iv; a = av; b = bv;
        inj_en = ie; inj_lane = il; inj_bit = ib;
        out_ready = ordy; clr_cnt = clr;
        #1;
        if (r) begin
            q.delete();
            m_cnt = 0;
        end else begin
            check_eq("in_ready", 32'(in_ready), 32'(!out_valid || ordy));
            if (out_valid && ordy && (q.size() > 0)) begin
                e = q.pop_front();
                if (e.f && (m_cnt < CMAX)) m_cnt++;
            end
            if (clr) m_cnt = 0;
            if (iv && in_ready) begin
                e.s = {1'b0, av} + {1'b0, bv};
                e.f = ie && (il != 2'd3) && (int'(ib) <= WIDTH);
                q.push_back(e);
            end
        end
        @(posedge clk);
        @(negedge clk);
        if (out_valid) begin
            if (q.size() == 0) begin
                check_eq("spurious_valid", 32'(out_valid), 32'd0);
            end else begin
                check_eq("sum", 32'(sum), 32'(q[0].s));
                check_eq("fault_flag", 32'(fault_flag), 32'(q[0].f));
            end
        end
        check_eq("fault_cnt", 32'(fault_cnt), 32'(m_cnt));
    endtask

    task automatic idle(input bit ordy);
        step(1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 2'd3, 4'd0, ordy, 1'b0);
    endtask

    initial begin
        m_cnt = 0;
        step(1'b1, 1'b0, 8'h00, 8'h00, 1'b0, 2'd3, 4'd0, 1'b1, 1'b0);
        step(1'b1, 1'b0, 8'h00, 8'h00, 1'b0, 2'd3, 4'd0, 1'b1, 1'b0);
        check_eq("rst_out_valid", 32'(out_valid), 32'd0);
        check_eq("rst_sum", 32'(sum), 32'd0);
        check_eq("rst_fault_flag", 32'(fault_flag), 32'd0);
        check_eq("rst_fault_cnt", 32'(fault_cnt), 32'd0);

        // Plain carry-through, two-cycle latency.
        step(1'b0, 1'b1, 8'hFF, 8'h01, 1'b0, 2'd3, 4'd0, 1'b1, 1'b0);
        check_eq("lat_early", 32'(out_valid), 32'd0);
        idle(1'b1);
        check_eq("lat_valid", 32'(out_valid), 32'd1);
        check_eq("ff_sum", 32'(sum), 32'h100);
        check_eq("ff_flag", 32'(fault_flag), 32'd0);
        idle(1'b1);

        // Sum-bit fault in lane 1.
        step(1'b0, 1'b1, 8'h0F, 8'h01, 1'b1, 2'd1, 4'd3, 1'b1, 1'b0);
        idle(1'b1);
        check_eq("inj_sum", 32'(sum), 32'h010);
        check_eq("inj_flag", 32'(fault_flag), 32'd1);
        idle(1'b1);
        check_eq("inj_cnt", 32'(fault_cnt), 32'd1);

        // Carry-out fault in lane 2, then a no-op tag.
        step(1'b0, 1'b1, 8'h80, 8'h80, 1'b1, 2'd2, 4'd8, 1'b1, 1'b0);
        idle(1'b1);
        check_eq("cinj_sum", 32'(sum), 32'h100);
        check_eq("cinj_flag", 32'(fault_flag), 32'd1);
        step(1'b0, 1'b1, 8'h80, 8'h80, 1'b1, 2'd3, 4'd8, 1'b1, 1'b0);
        idle(1'b1);
        check_eq("nolane_flag", 32'(fault_flag), 32'd0);
        idle(1'b1);

        // Backpressure: only two entries fit while the output is stalled.
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 1'b1, 8'($urandom), 8'($urandom), 1'b0, 2'd3, 4'd0, 1'b0, 1'b0);
        end
        check_eq("bp_in_ready", 32'(in_ready), 32'd0);
        check_eq("bp_held", 32'(q.size()), 32'd2);
        check_eq("bp_out_valid", 32'(out_valid), 32'd1);
        for (int i = 0; i < 4; i++) idle(1'b1);
        check_eq("bp_drained", 32'(q.size()), 32'd0);

        // Saturation, then clear colliding with a faulty transfer.
        step(1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 2'd3, 4'd0, 1'b1, 1'b1);
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 1'b1, 8'($urandom), 8'($urandom), 1'b1, 2'd0,
                 IW'($urandom_range(0, WIDTH)), 1'b1, 1'b0);
        end
        for (int i = 0; i < 3; i++) idle(1'b1);
        check_eq("sat_cnt", 32'(fault_cnt), 32'd3);
        step(1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 2'd3, 4'd0, 1'b1, 1'b1);
        step(1'b0, 1'b1, 8'h12, 8'h34, 1'b1, 2'd0, 4'd0, 1'b1, 1'b0);
        idle(1'b1);
        check_eq("clr_pre_flag", 32'(fault_flag), 32'd1);
        step(1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 2'd3, 4'd0, 1'b1, 1'b1);
        check_eq("clr_prio", 32'(fault_cnt), 32'd0);

        // Random traffic.
        for (int i = 0; i < 300; i++) begin
            step(1'b0, ($urandom_range(0, 3) != 0), 8'($urandom), 8'($urandom),
                 ($urandom_range(0, 2) == 0), 2'($urandom), IW'($urandom_range(0, WIDTH)),
                 ($urandom_range(0, 3) != 0), ($urandom_range(0, 15) == 0));
        end
        for (int i = 0; i < 5; i++) idle(1'b1);
        check_eq("rand_drained", 32'(q.size()), 32'd0);

        // Reset with two transactions in flight.
        step(1'b0, 1'b1, 8'h11, 8'h22, 1'b1, 2'd0, 4'd1, 1'b0, 1'b0);
        step(1'b0, 1'b1, 8'h33, 8'h44, 1'b0, 2'd3, 4'd0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 8'h00, 8'h00, 1'b0, 2'd3, 4'd0, 1'b1, 1'b0);
        check_eq("mid_rst_valid", 32'(out_valid), 32'd0);
        for (int i = 0; i < 4; i++) begin
            idle(1'b1);
            check_eq("post_rst_valid", 32'(out_valid), 32'd0);
        end
        check_eq("post_rst_cnt", 32'(fault_cnt), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
